// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: resynchronises rs232_rx, validates the start bit at mid-bit,
// shifts in 8 data bits LSB-first and checks the stop bit before committing a byte.
module uart_rx_8n1 #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rs232_rx,
  output logic       rx_data_valid,
  output logic [7:0] rx_data_out,
  output logic       rx_frame_err,
  output logic [2:0] rx_state
);

  // BAUD_DIV must be at least 4 so that the half-bit start check is meaningful.
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = ($clog2(BAUD_DIV) < 16) ? 16 : $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic             rx_meta, rx_s, rx_d;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             valid_n, err_n;

  // Output handshake: rx_data_valid is a one-cycle strobe with no backpressure;
  // rx_data_out is stable from that edge until the next good frame.
  assign rx_state = state;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_d          <= 1'b1;
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_data_out   <= '0;
      rx_data_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_meta       <= rs232_rx;
      rx_s          <= rx_meta;
      rx_d          <= rx_s;
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_idx_n;
      shift         <= shift_n;
      rx_data_out   <= data_n;
      rx_data_valid <= valid_n;
      rx_frame_err  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = rx_data_out;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_d && !rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = S_DATA;
            bit_idx_n = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == BAUD_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          if (bit_idx == 3'd7) state_n = S_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == BAUD_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      // Leave only once the line is released, so a held-low line makes no frames.
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: a fast instance (16 clocks/bit) for the directed, table and
// random tests, and a default-rate instance that receives one frame.
module tb_uart_rx_8n1;

  localparam int BD     = 16;
  localparam int BD_DEF = 1250;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx, rx_def;
  logic       valid, err, valid_def, err_def;
  logic [7:0] data, data_def;
  logic [2:0] st, st_def;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0, err_cnt = 0, exp_err_cnt = 0, exp_valid_cnt = 0;
  int def_valid_cnt = 0, def_err_cnt = 0;
  int fall_cyc = 0, last_valid_cyc = 0;
  logic prev_valid = 1'b0, prev_err = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] def_q[$];
  logic [7:0] e_main, e_def;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_err;
  } vec_t;
  vec_t vecs[6];

  uart_rx_8n1 #(.CLK_FREQ(1600), .BAUD_RATE(100)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rs232_rx(rx),
    .rx_data_valid(valid), .rx_data_out(data), .rx_frame_err(err), .rx_state(st)
  );

  uart_rx_8n1 dut_def (
    .clk_in(clk), .rst_n_in(rst_n), .rs232_rx(rx_def),
    .rx_data_valid(valid_def), .rx_data_out(data_def), .rx_frame_err(err_def), .rx_state(st_def)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Line-level model of one 8N1 frame; stop_bits>1 stretches the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_bits);
    fall_cyc = cyc;
    hold(1'b0, BD);
    for (int i = 0; i < 8; i++) hold(d[i], BD);
    hold(stop_v, BD * stop_bits);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    exp_valid_cnt++;
    send_frame(d, 1'b1, 1);
    last_good = d;
  endtask

  // Scoreboard for the fast instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        chk("valid_width", {31'd0, prev_valid}, 32'd0);
        chk("pulse_excl", {31'd0, err}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=%0h required=none", data);
        end else begin
          e_main = exp_q.pop_front();
          chk("rx_byte", {24'd0, data}, {24'd0, e_main});
        end
      end
      if (err) begin
        err_cnt++;
        chk("err_width", {31'd0, prev_err}, 32'd0);
      end
    end
    prev_valid = valid;
    prev_err   = err;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_def) def_err_cnt++;
      if (valid_def) begin
        def_valid_cnt++;
        if (def_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL def_unexpected_valid actual=%0h required=none", data_def);
        end else begin
          e_def = def_q.pop_front();
          chk("def_rx_byte", {24'd0, data_def}, {24'd0, e_def});
        end
      end
    end
  end

  initial begin
    int v0, e0, gap;
    logic [7:0] d;
    logic ok;

    vecs[0] = '{data: 8'h41, stop: 1'b1, gap: 0, exp_valid: 1, exp_err: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_valid: 1, exp_err: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 5, exp_valid: 1, exp_err: 0};
    vecs[3] = '{data: 8'h5A, stop: 1'b0, gap: 6, exp_valid: 0, exp_err: 1};
    vecs[4] = '{data: 8'h80, stop: 1'b1, gap: 0, exp_valid: 1, exp_err: 0};
    vecs[5] = '{data: 8'h01, stop: 1'b1, gap: 3, exp_valid: 1, exp_err: 0};

    rst_n  = 1'b0;
    rx     = 1'b1;
    rx_def = 1'b1;
    @(negedge clk);

    // Reset held with a toggling line.
    for (int i = 0; i < 24; i++) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reset_outputs", {22'd0, valid, err, data}, 32'd0);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * BD) @(negedge clk);
    chk("idle_no_valid", valid_cnt, 0);
    chk("idle_no_err", err_cnt, 0);

    // Single byte with latency check.
    send_good(8'h35);
    hold(1'b1, 2);
    chk("single_count", valid_cnt, 1);
    chk("single_data", {24'd0, data}, 32'h35);
    chk("latency_lo", {31'd0, (last_valid_cyc - fall_cyc) >= 155}, 1);
    chk("latency_hi", {31'd0, (last_valid_cyc - fall_cyc) <= 157}, 1);

    // Back-to-back with no idle gap.
    v0 = valid_cnt;
    send_good(8'h00);
    send_good(8'hFF);
    hold(1'b1, 2);
    chk("b2b_count", valid_cnt - v0, 2);
    chk("b2b_no_err", err_cnt, 0);

    // Short glitch is a false start; next frame still lands.
    v0 = valid_cnt;
    e0 = err_cnt;
    hold(1'b0, BD / 4);
    hold(1'b1, 3 * BD);
    chk("glitch_no_valid", valid_cnt - v0, 0);
    chk("glitch_no_err", err_cnt - e0, 0);
    send_good(8'h39);
    hold(1'b1, 2);
    chk("after_glitch_data", {24'd0, data}, 32'h39);

    // Frame error with the line held low afterwards.
    send_good(8'h31);
    hold(1'b1, BD);
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'hA5, 1'b0, 4);
    exp_err_cnt++;
    hold(1'b1, 2 * BD);
    chk("ferr_count", err_cnt - e0, 1);
    chk("ferr_no_valid", valid_cnt - v0, 0);
    chk("ferr_data_hold", {24'd0, data}, 32'h31);
    send_good(8'h32);
    hold(1'b1, 2);
    chk("after_ferr_data", {24'd0, data}, 32'h32);

    // Reset in the middle of data bit 4.
    v0 = valid_cnt;
    e0 = err_cnt;
    d = 8'h55;
    hold(1'b0, BD);
    for (int i = 0; i < 4; i++) hold(d[i], BD);
    hold(d[4], BD / 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {22'd0, valid, err, data}, 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (2 * BD) @(negedge clk);
    chk("midreset_no_valid", valid_cnt - v0, 0);
    chk("midreset_no_err", err_cnt - e0, 0);
    chk("midreset_data", {24'd0, data}, 32'd0);
    send_good(8'h7E);
    hold(1'b1, 2);
    chk("after_reset_data", {24'd0, data}, 32'h7E);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      if (vecs[i].stop) begin
        exp_q.push_back(vecs[i].data);
        exp_valid_cnt++;
      end
      exp_err_cnt += vecs[i].exp_err;
      send_frame(vecs[i].data, vecs[i].stop, 1);
      if (vecs[i].stop) last_good = vecs[i].data;
      chk("vec_valid", valid_cnt - v0, vecs[i].exp_valid);
      chk("vec_err", err_cnt - e0, vecs[i].exp_err);
      chk("vec_data", {24'd0, data}, {24'd0, last_good});
      if (vecs[i].gap > 0) hold(1'b1, vecs[i].gap);
    end

    // Random frames, mostly good, random gaps.
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, BD);
      if (ok) begin
        send_good(d);
      end else begin
        exp_err_cnt++;
        send_frame(d, 1'b0, 1);
        if (gap < 3) gap = 3;
      end
      chk("rand_data", {24'd0, data}, {24'd0, last_good});
      if (gap > 0) hold(1'b1, gap);
    end
    hold(1'b1, 2 * BD);
    chk("total_valid", valid_cnt, exp_valid_cnt);
    chk("total_err", err_cnt, exp_err_cnt);
    chk("queue_drained", exp_q.size(), 0);

    // One frame at the default rate.
    d = 8'($urandom_range(0, 255));
    def_q.push_back(d);
    rx_def = 1'b0;
    repeat (BD_DEF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_def = d[i];
      repeat (BD_DEF) @(negedge clk);
    end
    rx_def = 1'b1;
    repeat (BD_DEF + 10) @(negedge clk);
    chk("def_valid_count", def_valid_cnt, 1);
    chk("def_err_count", def_err_cnt, 0);
    chk("def_data", {24'd0, data_def}, {24'd0, d});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Serial receiver that turns the `rs232_rx` pin into bytes for the display path. It resynchronises the asynchronous line and validates the start bit at mid-bit. It samples 8 data bits LSB-first, checks the stop bit, and emits each good byte with a single-cycle strobe. The byte and strobe feed the ASCII-to-digit decoder and the 6-digit shift register in front of the 74HC595 segment scanner. Frame errors are flagged separately and never produce a data strobe.

## Interface
- `CLK_FREQ`, 12_000_000, clk_in frequency in Hz.
- `BAUD_RATE`, 9600, line rate in bit/s.
- Derived constants:
  - `BAUD_DIV = CLK_FREQ/BAUD_RATE` (1250 at defaults), integer division.
  - `HALF_DIV = BAUD_DIV/2` (625).
  - `BAUD_DIV >= 4` is required.

- `clk_in` input 1: system clock.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `rs232_rx` input 1: asynchronous serial line; idles high; 8N1 framing.
- `rx_data_valid` output 1: one-cycle pulse when `rx_data_out` takes a new good byte.
- `rx_data_out` output 8: last correctly received byte; held between frames.
- `rx_frame_err` output 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- Synchroniser:
  - 2-FF synchroniser on `rs232_rx`, giving `rx_s`. Both flops reset to 1.
  - A third register `rx_d` (reset 1) provides edge detection.
- Counters:
  - Bit-period counter `cnt` is wide enough for `BAUD_DIV-1` (16 bits at defaults).
  - Bit index `bit_idx` is 3 bits.
  - Shift register `shift` is 8 bits.
- State machine: IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
  - IDLE: on `rx_d==1 && rx_s==0` (falling edge), go to START with `cnt<=0`.
  - START: `cnt` increments. At `cnt==HALF_DIV-1`, sample `rx_s`:
    - 0: go to DATA with `cnt<=0`, `bit_idx<=0`.
    - 1: false start; return to IDLE with no output activity.
  - DATA: `cnt` increments. At `cnt==BAUD_DIV-1`:
    - `shift <= {rx_s, shift[7:1]}` (LSB received first), `cnt<=0`.
    - If `bit_idx==7`, go to STOP; otherwise `bit_idx++`.
  - STOP: at `cnt==BAUD_DIV-1`, sample `rx_s`:
    - 1: `rx_data_out<=shift`, `rx_data_valid<=1`, go to IDLE.
    - 0: `rx_frame_err<=1`, go to BREAK. `rx_data_out` is unchanged.
  - BREAK: stay until `rx_s==1`, then go to IDLE. This covers a line held low (break condition) without generating spurious frames.
- Outputs:
  - All outputs are registered.
  - `rx_data_valid` and `rx_frame_err` default to 0 every cycle other than the setting cycle.
  - The two pulses are mutually exclusive.
- Edge detection applies in IDLE only. Line activity in other states is ignored, apart from the samples defined above.

## Timing
- Reset values: `rx_data_valid=0`, `rx_data_out=8'h00`, `rx_frame_err=0`, state IDLE, `cnt=0`, `bit_idx=0`, `shift=0`.
- Reset is asynchronous and may be asserted mid-frame. It aborts the frame immediately with no pulse. After release, the receiver waits for a fresh falling edge.
- Synchroniser delay: the falling edge on the pin reaches `rx_s` 2 clocks later, and IDLE detects it on the next edge (edge E).
- Sample points, relative to E:
  - Start bit: `HALF_DIV` clocks after E.
  - Data bit k (k=0..7): `HALF_DIV + (k+1)*BAUD_DIV` clocks after E.
  - Stop bit: `HALF_DIV + 9*BAUD_DIV` clocks after E.
- Output timing:
  - `rx_data_valid` / `rx_frame_err` are high on the cycle after the stop sample, for exactly 1 clock.
  - `rx_data_out` changes on the same edge that raises `rx_data_valid`.
- Back-to-back frames: after the stop sample the FSM is in IDLE roughly half a bit before the nominal stop end. A start bit immediately following the stop bit must be caught, with no idle gap needed.
- Tolerance: sampling at mid-bit tolerates about ±4% total baud mismatch.
- Data bits are not re-verified; a glitch inside a data bit is captured as-is.

## Test plan
Benches use `CLK_FREQ=1600`, `BAUD_RATE=100` (`BAUD_DIV=16`) for speed, plus one run at defaults.
- Reset: hold `rst_n_in=0` with `rs232_rx` toggling -> all outputs 0. After release with line idle, no pulse within 20 bit times.
- Single byte: send 0x35 ("5") -> exactly one `rx_data_valid` pulse, 1 clock wide. `rx_data_out=8'h35` from that edge onward. Pulse occurs `3+HALF_DIV+9*BAUD_DIV+1` clocks after the pin's falling edge, ±1.
- Back-to-back: send 0x00 then 0xFF with zero idle between stop and next start -> two pulses with values 0x00 then 0xFF; `rx_frame_err` never asserts.
- Glitch: pulse line low for `BAUD_DIV/4` clocks -> no valid, no frame_err. The next frame 0x39 is received correctly.
- Frame error: first receive 0x31, then send 0xA5 with stop bit 0 and hold low for 3 bit times before releasing -> one `rx_frame_err` pulse, no valid, `rx_data_out` stays 0x31. A following 0x32 is received correctly.
- Mid-frame reset: assert reset during data bit 4 of 0x55 -> no pulses and `rx_data_out=0`. After release, a full 0x7E frame yields a valid pulse with 0x7E.
